// File: rtl/alu.sv
// alu: combinational 32-bit arithmetic/logic unit for the multi-cycle core.
// aluResult, zero and div_by_zero follow the inputs with no latency;
// result_q holds a registered copy of the last result for debug and flags.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_MUL    = 4'b0010,
        OP_DIV    = 4'b0011,
        OP_AND    = 4'b0100,
        OP_OR     = 4'b0101,
        OP_XOR    = 4'b0110,
        OP_LS     = 4'b0111,
        OP_RS     = 4'b1000,
        OP_EQ     = 4'b1001,
        OP_NEQ    = 4'b1010,
        OP_LT     = 4'b1011,
        OP_LTE    = 4'b1100,
        OP_GT     = 4'b1101,
        OP_GTE    = 4'b1110,
        OP_UNUSED = 4'b1111
    } alu_op_e;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    alu_op_e                 op;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   shamt;
    logic        [WIDTH-1:0] quotient;
    logic        [WIDTH-1:0] result_d;

    assign op    = alu_op_e'(aluControl);
    assign a_s   = $signed(srcA);
    assign b_s   = $signed(srcB);
    assign shamt = srcB[SHW-1:0];

    // Signed division with the two corner cases pinned to defined values,
    // so the divider itself never sees a zero divisor or an overflowing pair.
    always_comb begin
        // NOTE: every branch of a combinational block must assign its outputs;
        // a default first guarantees that and prevents an inferred latch.
        quotient = '1;
        if (srcB == '0) begin
            quotient = '1;
        end else if (srcA == MIN_NEG && srcB == '1) begin
            quotient = MIN_NEG;
        end else begin
            quotient = WIDTH'(a_s / b_s);
        end
    end

    // Opcode decode: one result per operation, compares zero-extended to WIDTH.
    always_comb begin
        result_d = '0;
        unique case (op)
            OP_ADD:    result_d = srcA + srcB;
            OP_SUB:    result_d = srcA - srcB;
            OP_MUL:    result_d = srcA * srcB;
            OP_DIV:    result_d = quotient;
            OP_AND:    result_d = srcA & srcB;
            OP_OR:     result_d = srcA | srcB;
            OP_XOR:    result_d = srcA ^ srcB;
            OP_LS:     result_d = srcA << shamt;
            OP_RS:     result_d = srcA >> shamt;
            OP_EQ:     result_d = {{(WIDTH-1){1'b0}}, (a_s == b_s)};
            OP_NEQ:    result_d = {{(WIDTH-1){1'b0}}, (a_s != b_s)};
            OP_LT:     result_d = {{(WIDTH-1){1'b0}}, (a_s <  b_s)};
            OP_LTE:    result_d = {{(WIDTH-1){1'b0}}, (a_s <= b_s)};
            OP_GT:     result_d = {{(WIDTH-1){1'b0}}, (a_s >  b_s)};
            OP_GTE:    result_d = {{(WIDTH-1){1'b0}}, (a_s >= b_s)};
            OP_UNUSED: result_d = '0;
            default:   result_d = '0;
        endcase
    end

    assign aluResult   = result_d;
    assign zero        = (result_d == '0);
    assign div_by_zero = (op == OP_DIV) && (srcB == '0);

    // Debug copy of the result, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!resetn) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed expected values for alu.
module tb_alu;

    logic        clk;
    logic        resetn;
    logic [3:0]  aluControl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] aluResult;
    logic        zero;
    logic [31:0] result_q;
    logic        div_by_zero;

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .aluControl  (aluControl),
        .srcA        (srcA),
        .srcB        (srcB),
        .aluResult   (aluResult),
        .zero        (zero),
        .result_q    (result_q),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        aluControl = op;
        srcA       = a;
        srcB       = b;
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b);
        check(tag, aluResult, exp);
    endtask

    initial begin
        resetn     = 1'b0;
        aluControl = 4'b0000;
        srcA       = 32'd0;
        srcB       = 32'd0;

        @(negedge clk);
        drive(4'b0000, 32'd9, 32'd9);
        @(posedge clk); #1;
        check("reset_result_q", result_q, 32'd0);
        check("reset_comb_add", aluResult, 32'd18);
        @(negedge clk);
        resetn = 1'b1;

        // ADD/SUB wrap
        vec("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        vec("sub_neg", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
        check("sub_neg_zero", {31'd0, zero}, 32'd0);
        vec("add_42", 4'b0000, 32'd12, 32'd30, 32'd42);

        // logic and shifts
        vec("and", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        vec("or",  4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        vec("xor", 4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        vec("ls_31", 4'b0111, 32'd1, 32'd31, 32'h8000_0000);
        vec("ls_33", 4'b0111, 32'd1, 32'd33, 32'd2);
        vec("rs_4",  4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000);

        // signed compares, -1 vs 1
        vec("lt_m1_1",  4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd1);
        vec("lte_m1_1", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1);
        vec("gt_m1_1",  4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd0);
        vec("gte_m1_1", 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'd0);
        vec("eq_m1_1",  4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        vec("neq_m1_1", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd1);
        // equal operands
        vec("lte_7_7", 4'b1100, 32'd7, 32'd7, 32'd1);
        vec("gte_7_7", 4'b1110, 32'd7, 32'd7, 32'd1);
        vec("lt_7_7",  4'b1011, 32'd7, 32'd7, 32'd0);
        vec("eq_7_7",  4'b1001, 32'd7, 32'd7, 32'd1);
        vec("gt_1_m1", 4'b1101, 32'd1, 32'hFFFF_FFFF, 32'd1);

        // MUL/DIV
        vec("mul_wrap", 4'b0010, 32'h0001_0000, 32'h0001_0000, 32'd0);
        vec("mul_42",   4'b0010, 32'd6, 32'd7, 32'd42);
        vec("div_m7_2", 4'b0011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        check("div_m7_2_dbz", {31'd0, div_by_zero}, 32'd0);
        vec("div_5_0",  4'b0011, 32'd5, 32'd0, 32'hFFFF_FFFF);
        check("div_5_0_dbz", {31'd0, div_by_zero}, 32'd1);
        vec("div_ovf",  4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        vec("div_100_7", 4'b0011, 32'd100, 32'd7, 32'd14);
        vec("add_b0", 4'b0000, 32'd5, 32'd0, 32'd5);
        check("add_b0_dbz", {31'd0, div_by_zero}, 32'd0);

        // unused opcode
        vec("unused_a", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
        vec("unused_b", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        // register and reset behaviour
        @(negedge clk);
        drive(4'b0000, 32'd2, 32'd3);
        @(posedge clk); #1;
        check("reg_5", result_q, 32'd5);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("reg_reset", result_q, 32'd0);
        check("reg_reset_comb", aluResult, 32'd5);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("reg_release", result_q, 32'd5);
        @(negedge clk);
        drive(4'b0001, 32'd10, 32'd4);
        @(posedge clk); #1;
        check("reg_follow", result_q, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational 32-bit arithmetic/logic unit for the multi-cycle RISC-V-style core. The core drives the operands and a 4-bit opcode in one state and samples `aluResult` in the next state. The unit also keeps a registered copy of the last result for debug and flag use. This is the core's only arithmetic datapath: address generation for LW/SW, branch-condition evaluation, branch/JAL target computation, and all R/I-type ops.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is required.

Ports:
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: synchronous, active-low reset. Affects registered outputs only.
- `aluControl`  in  4: operation select.
- `srcA`  in  32: operand A.
- `srcB`  in  32: operand B.
- `aluResult`  out  32: combinational result.
- `zero`  out  1: combinational, 1 when `aluResult == 0`.
- `result_q`  out  32: `aluResult` registered on every rising clk.
- `div_by_zero`  out  1: combinational, 1 when op is DIV and `srcB == 0`.

## Operation
`aluControl` encodings; all arithmetic is modulo 2^32:
- 0000 ADD: `srcA + srcB`. Carry discarded.
- 0001 SUB: `srcA - srcB`. Borrow discarded.
- 0010 MUL: low 32 bits of `srcA * srcB`.
- 0011 DIV: signed quotient, truncated toward zero.
  - `srcB == 0` gives 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF gives 0x80000000.
- 0100 AND, 0101 OR, 0110 XOR: bitwise.
- 0111 LS: `srcA << srcB[4:0]`. Upper bits of `srcB` ignored.
- 1000 RS: logical right shift, `srcA >> srcB[4:0]`, zero fill.
- Comparisons return 32'd1 if true, else 32'd0. All are signed two's-complement.
  - 1001 EQ: `srcA == srcB`.
  - 1010 NEQ: `srcA != srcB`.
  - 1011 LT: `srcA < srcB`.
  - 1100 LTE: `srcA <= srcB`.
  - 1101 GT: `srcA > srcB`.
  - 1110 GTE: `srcA >= srcB`.
- 1111 (unused): `aluResult` = 0.
- No internal state other than `result_q`. No X propagation: every opcode produces a defined value.

## Timing
- `aluResult`, `zero`, `div_by_zero`: purely combinational, zero-cycle latency. Must settle within one clk period of any operand or opcode change.
- `result_q`: updated at every rising clk edge with the current `aluResult`.
- Reset:
  - `resetn` = 0 at a rising edge sets `result_q` = 0.
  - Combinational outputs keep following inputs during reset.
  - Reset mid-operation has no effect on `aluResult`.
- No handshake: the caller holds operands stable for one full cycle before sampling.
- Simultaneous opcode and operand change: the output reflects the new combination only; no glitch requirement beyond settling.

## Test plan
- ADD/SUB wrap:
  - ADD 0xFFFFFFFF + 1 -> 0, `zero`=1.
  - SUB 3 - 5 -> 0xFFFFFFFE.
  - ADD 12 + 30 -> 42.
- Logic and shifts:
  - AND/OR/XOR of 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00.
  - LS 1 by 31 -> 0x80000000.
  - LS 1 by srcB=33 -> 2.
  - RS 0x80000000 by 4 -> 0x08000000.
- Signed compares with `srcA`=0xFFFFFFFF (-1), `srcB`=1:
  - LT -> 1, LTE -> 1, GT -> 0, GTE -> 0, EQ -> 0, NEQ -> 1.
  - Equal operands 7,7: LTE=1, GTE=1, LT=0.
- MUL/DIV:
  - MUL 0x10000 * 0x10000 -> 0.
  - MUL 6 * 7 -> 42.
  - DIV -7/2 -> 0xFFFFFFFD.
  - DIV 5/0 -> 0xFFFFFFFF, `div_by_zero`=1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Unused opcode 1111, any operands -> 0.
- Register/reset:
  - ADD 2+3 -> `result_q`=5 one edge later.
  - Assert `resetn`=0 for one edge -> `result_q`=0 while `aluResult` still 5.
  - Deassert -> `result_q`=5 on the next edge.
